mem_arbiter: RTL and testbench

- Shares one single-port synchronous word RAM between the CPU's read channel (m_in_*), its write channel (m_out_*) and an external loader/debug port (ext_*).
- Latches the CPU's one-cycle request pulses and arbitrates between the CPU and the external port.
- Performs byte/half/word lane steering and returns one-cycle ready/ack pulses.
- Sits between the CPU core and the on-chip RAM.

---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/mem_arbiter_if.sv | 55 +++++
 rtl/mem_lane_steer.sv | 44 ++++
 rtl/mem_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types for the CPU/external RAM arbiter
package mem_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } size_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ACCESS     = 3'd1,
        ST_READ_CAPT  = 3'd2,
        ST_WRITE_DONE = 3'd3,
        ST_RESP       = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        REQ_RD  = 2'd0,
        REQ_WR  = 2'd1,
        REQ_EXT = 2'd2
    } req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - CPU, external and RAM buses of the arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 14
);
    // CPU read channel
    logic [1:0]        m_in_sig_read;
    logic [31:0]       m_in_addr;
    logic [31:0]       m_in_data;
    logic              m_in_ready;
    // CPU write channel
    logic [1:0]        m_out_sig_write;
    logic [31:0]       m_out_addr;
    logic [31:0]       m_out_data;
    logic              m_out_ready;
    // external loader/debug port
    logic              ext_req;
    logic              ext_we;
    logic [31:0]       ext_addr;
    logic [31:0]       ext_wdata;
    logic              ext_ack;
    logic [31:0]       ext_rdata;
    // RAM side
    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              err;

    modport slave (
        input  m_in_sig_read, m_in_addr,
        output m_in_data, m_in_ready,
        input  m_out_sig_write, m_out_addr, m_out_data,
        output m_out_ready,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_ack, ext_rdata,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata,
        output err
    );

    modport master (
        output m_in_sig_read, m_in_addr,
        input  m_in_data, m_in_ready,
        output m_out_sig_write, m_out_addr, m_out_data,
        input  m_out_ready,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_ack, ext_rdata,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata,
        input  err
    );

endinterface

// File: rtl/mem_lane_steer.sv
// rtl/mem_lane_steer.sv - byte/half/word lane steering for RAM writes and reads
module mem_lane_steer
    import mem_pkg::*;
(
    input  size_t              size,
    input  logic [1:0]         addr_lo,
    input  logic [DATA_W-1:0]  wdata_in,
    output logic [3:0]         be,
    output logic [DATA_W-1:0]  wdata_out,
    input  logic [DATA_W-1:0]  rdata_in,
    output logic [DATA_W-1:0]  rdata_out
);

    // Replicate narrow write data on every lane and pick the addressed lane on reads
    always_comb begin
        be        = 4'b0000;
        wdata_out = '0;
        rdata_out = '0;
        case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_out = {4{wdata_in[7:0]}};
                rdata_out = {24'd0, rdata_in[{addr_lo, 3'b000} +: 8]};
            end
            SZ_HALF: begin
                // addr_lo[0] is deliberately ignored: halves are always aligned
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_out = {2{wdata_in[15:0]}};
                rdata_out = {16'd0, (addr_lo[1] ? rdata_in[31:16] : rdata_in[15:0])};
            end
            SZ_WORD: begin
                be        = 4'b1111;
                wdata_out = wdata_in;
                rdata_out = rdata_in;
            end
            default: begin
                be        = 4'b0000;
                wdata_out = '0;
                rdata_out = '0;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one word RAM between CPU read/write and an external port
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    state_t            state;
    state_t            state_nx;

    // latched CPU requests; a channel stays pending until its access completes
    logic              rd_pend;
    size_t             rd_size;
    logic [ADDR_W+1:0] rd_addr;
    logic              wr_pend;
    size_t             wr_size;
    logic [ADDR_W+1:0] wr_addr;
    logic [31:0]       wr_data;

    req_t              last_grant;
    req_t              cur_req;
    size_t             cur_size;
    logic [1:0]        cur_lo;

    logic              cpu_want;
    req_t              cpu_req;
    logic              do_grant;
    req_t              grant_req;

    size_t             g_size;
    logic [1:0]        g_lo;
    logic [ADDR_W-1:0] g_addr;
    logic [31:0]       g_wdata;
    logic              g_we;

    size_t             steer_size;
    logic [1:0]        steer_lo;
    logic [3:0]        steer_be;
    logic [31:0]       steer_wdata;
    logic [31:0]       steer_rdata;

    // address bits above the RAM size alias by truncation; ext ignores the byte offset
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{bus.m_in_addr[31:ADDR_W+2], bus.m_out_addr[31:ADDR_W+2],
                                bus.ext_addr[31:ADDR_W+2], bus.ext_addr[1:0]};

    assign bus.mem_en = (state == ST_ACCESS);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and grant decision; the CPU's write beats its own read
    always_comb begin
        state_nx  = state;
        do_grant  = 1'b0;
        grant_req = REQ_RD;
        cpu_want  = rd_pend | wr_pend;
        cpu_req   = wr_pend ? REQ_WR : REQ_RD;
        case (state)
            ST_IDLE: begin
                if (cpu_want && bus.ext_req) begin
                    do_grant  = 1'b1;
                    grant_req = (last_grant == REQ_EXT) ? cpu_req : REQ_EXT;
                end else if (cpu_want) begin
                    do_grant  = 1'b1;
                    grant_req = cpu_req;
                end else if (bus.ext_req) begin
                    do_grant  = 1'b1;
                    grant_req = REQ_EXT;
                end
                if (do_grant) begin
                    state_nx = ST_ACCESS;
                end
            end
            ST_ACCESS:     state_nx = bus.mem_we ? ST_WRITE_DONE : ST_READ_CAPT;
            ST_READ_CAPT:  state_nx = ST_RESP;
            ST_WRITE_DONE: state_nx = ST_RESP;
            ST_RESP:       state_nx = ST_IDLE;
            default:       state_nx = ST_IDLE;
        endcase
    end

    // Select the granted requester's parameters; the steerer sees the grant in IDLE
    // and the registered access otherwise (it is only needed again at read capture)
    always_comb begin
        g_size  = rd_size;
        g_lo    = rd_addr[1:0];
        g_addr  = rd_addr[ADDR_W+1:2];
        g_wdata = '0;
        g_we    = 1'b0;
        case (grant_req)
            REQ_WR: begin
                g_size  = wr_size;
                g_lo    = wr_addr[1:0];
                g_addr  = wr_addr[ADDR_W+1:2];
                g_wdata = wr_data;
                g_we    = 1'b1;
            end
            REQ_EXT: begin
                g_size  = SZ_WORD;
                g_lo    = 2'b00;
                g_addr  = bus.ext_addr[ADDR_W+1:2];
                g_wdata = bus.ext_wdata;
                g_we    = bus.ext_we;
            end
            default: begin
                g_size  = rd_size;
                g_lo    = rd_addr[1:0];
                g_addr  = rd_addr[ADDR_W+1:2];
                g_wdata = '0;
                g_we    = 1'b0;
            end
        endcase
        steer_size = (state == ST_IDLE) ? g_size : cur_size;
        steer_lo   = (state == ST_IDLE) ? g_lo : cur_lo;
    end

    mem_lane_steer u_steer (
        .size      (steer_size),
        .addr_lo   (steer_lo),
        .wdata_in  (g_wdata),
        .be        (steer_be),
        .wdata_out (steer_wdata),
        .rdata_in  (bus.mem_rdata),
        .rdata_out (steer_rdata)
    );

    // Request capture, RAM command registers and one-cycle response pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend         <= 1'b0;
            rd_size         <= SZ_NONE;
            rd_addr         <= '0;
            wr_pend         <= 1'b0;
            wr_size         <= SZ_NONE;
            wr_addr         <= '0;
            wr_data         <= '0;
            last_grant      <= REQ_EXT;
            cur_req         <= REQ_RD;
            cur_size        <= SZ_NONE;
            cur_lo          <= 2'b00;
            bus.mem_we      <= 1'b0;
            bus.mem_be      <= 4'b0000;
            bus.mem_addr    <= '0;
            bus.mem_wdata   <= '0;
            bus.m_in_data   <= '0;
            bus.m_in_ready  <= 1'b0;
            bus.m_out_ready <= 1'b0;
            bus.ext_ack     <= 1'b0;
            bus.ext_rdata   <= '0;
            bus.err         <= 1'b0;
        end else begin
            bus.m_in_ready  <= 1'b0;
            bus.m_out_ready <= 1'b0;
            bus.ext_ack     <= 1'b0;

            // a pulse on a busy channel is dropped and flagged
            if (bus.m_in_sig_read != 2'd0) begin
                if (rd_pend) begin
                    bus.err <= 1'b1;
                end else begin
                    rd_pend <= 1'b1;
                    rd_size <= size_t'(bus.m_in_sig_read);
                    rd_addr <= bus.m_in_addr[ADDR_W+1:0];
                end
            end
            if (bus.m_out_sig_write != 2'd0) begin
                if (wr_pend) begin
                    bus.err <= 1'b1;
                end else begin
                    wr_pend <= 1'b1;
                    wr_size <= size_t'(bus.m_out_sig_write);
                    wr_addr <= bus.m_out_addr[ADDR_W+1:0];
                    wr_data <= bus.m_out_data;
                end
            end

            if (do_grant) begin
                last_grant    <= grant_req;
                cur_req       <= grant_req;
                cur_size      <= g_size;
                cur_lo        <= g_lo;
                bus.mem_we    <= g_we;
                bus.mem_be    <= steer_be;
                bus.mem_addr  <= g_addr;
                bus.mem_wdata <= steer_wdata;
            end

            if (state == ST_READ_CAPT) begin
                if (cur_req == REQ_EXT) begin
                    bus.ext_rdata <= steer_rdata;
                    bus.ext_ack   <= 1'b1;
                end else begin
                    bus.m_in_data  <= steer_rdata;
                    bus.m_in_ready <= 1'b1;
                    rd_pend        <= 1'b0;
                end
            end

            if (state == ST_WRITE_DONE) begin
                if (cur_req == REQ_EXT) begin
                    bus.ext_ack <= 1'b1;
                end else begin
                    bus.m_out_ready <= 1'b1;
                    wr_pend         <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a behavioural RAM
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int ADDR_W = 14;
    localparam int CH_RD  = 0;
    localparam int CH_WR  = 1;
    localparam int CH_EXT = 2;

    typedef struct {
        bit          is_rd;
        logic [31:0] data;
    } ext_exp_t;

    logic clk;
    logic reset;

    mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    int          exp_order[$];
    logic [31:0] exp_rd[$];
    ext_exp_t    exp_ext[$];

    logic [31:0] ram [0:(1<<ADDR_W)-1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RAM: read data appears the cycle after mem_en, read-before-write
    always @(posedge clk) begin
        if (bus.mem_en) begin
            bus.mem_rdata <= ram[bus.mem_addr];
            if (bus.mem_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus.mem_be[i]) ram[bus.mem_addr][8*i +: 8] = bus.mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // Monitor: every response pops the scoreboard
    always @(negedge clk) begin
        int       ord;
        ext_exp_t e;
        if (!reset) begin
            if (bus.m_in_ready) begin
                if (exp_order.size() == 0 || exp_rd.size() == 0) begin
                    check("unexpected_m_in_ready", 32'd1, 32'd0);
                end else begin
                    ord = exp_order.pop_front();
                    check("order_at_m_in_ready", ord, CH_RD);
                    check("m_in_data", bus.m_in_data, exp_rd.pop_front());
                end
            end
            if (bus.m_out_ready) begin
                if (exp_order.size() == 0) begin
                    check("unexpected_m_out_ready", 32'd1, 32'd0);
                end else begin
                    ord = exp_order.pop_front();
                    check("order_at_m_out_ready", ord, CH_WR);
                end
            end
            if (bus.ext_ack) begin
                if (exp_order.size() == 0 || exp_ext.size() == 0) begin
                    check("unexpected_ext_ack", 32'd1, 32'd0);
                end else begin
                    ord = exp_order.pop_front();
                    check("order_at_ext_ack", ord, CH_EXT);
                    e = exp_ext.pop_front();
                    if (e.is_rd) check("ext_rdata", bus.ext_rdata, e.data);
                end
            end
        end
    end

    task automatic exp_read(input logic [31:0] d);
        exp_order.push_back(CH_RD);
        exp_rd.push_back(d);
    endtask

    task automatic exp_write();
        exp_order.push_back(CH_WR);
    endtask

    task automatic exp_ext_op(input bit is_rd, input logic [31:0] d);
        ext_exp_t e;
        e.is_rd = is_rd;
        e.data  = d;
        exp_order.push_back(CH_EXT);
        exp_ext.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        bus.m_in_sig_read   = 2'd0;
        bus.m_out_sig_write = 2'd0;
        bus.ext_req         = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // One-cycle pulse on either or both CPU channels; returns in cycle 1
    task automatic cpu_pulse(input logic [1:0] rsz, input logic [31:0] raddr,
                             input logic [1:0] wsz, input logic [31:0] waddr,
                             input logic [31:0] wdata);
        @(posedge clk); #1;
        bus.m_in_sig_read   = rsz;
        bus.m_in_addr       = raddr;
        bus.m_out_sig_write = wsz;
        bus.m_out_addr      = waddr;
        bus.m_out_data      = wdata;
        @(posedge clk); #1;
        bus.m_in_sig_read   = 2'd0;
        bus.m_out_sig_write = 2'd0;
    endtask

    task automatic ext_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        bus.ext_req   = 1'b1;
        bus.ext_we    = we;
        bus.ext_addr  = addr;
        bus.ext_wdata = wdata;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (bus.ext_ack) break;
            n++;
        end
        if (n >= 100) check("ext_ack_timeout", 32'd1, 32'd0);
        bus.ext_req = 1'b0;
    endtask

    task automatic wait_quiet(input int tail);
        int n;
        n = 0;
        while (exp_order.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending_responses", exp_order.size(), 32'd0);
        repeat (tail) @(posedge clk);
        #1;
    endtask

    task automatic cpu_read(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] d);
        exp_read(d);
        cpu_pulse(sz, addr, 2'd0, 32'd0, 32'd0);
        wait_quiet(2);
    endtask

    task automatic cpu_write(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] d);
        exp_write();
        cpu_pulse(2'd0, 32'd0, sz, addr, d);
        wait_quiet(2);
    endtask

    // CPU read and external read issued together; ext_delay=1 raises ext_req one cycle later
    task automatic pair(input int ext_delay, input bit ext_first,
                        input logic [31:0] caddr, input logic [31:0] cdata,
                        input logic [31:0] eaddr, input logic [31:0] edata);
        if (ext_first) begin
            exp_ext_op(1'b1, edata);
            exp_read(cdata);
        end else begin
            exp_read(cdata);
            exp_ext_op(1'b1, edata);
        end
        fork
            cpu_pulse(2'd3, caddr, 2'd0, 32'd0, 32'd0);
            begin
                @(posedge clk); #1;
                if (ext_delay != 0) begin
                    @(posedge clk); #1;
                end
                ext_access(1'b0, eaddr, 32'd0);
            end
        join
        wait_quiet(2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 32'h0;
        ram[0] = 32'h12345678;
        ram[1] = 32'h11223344;
        ram[4] = 32'hDEADBEEF;

        reset               = 1'b1;
        bus.m_in_sig_read   = 2'd0;
        bus.m_in_addr       = 32'd0;
        bus.m_out_sig_write = 2'd0;
        bus.m_out_addr      = 32'd0;
        bus.m_out_data      = 32'd0;
        bus.ext_req         = 1'b0;
        bus.ext_we          = 1'b0;
        bus.ext_addr        = 32'd0;
        bus.ext_wdata       = 32'd0;
        do_reset();

        // reset state
        check("reset_m_in_ready", bus.m_in_ready, 32'd0);
        check("reset_m_in_data", bus.m_in_data, 32'd0);
        check("reset_mem_en", bus.mem_en, 32'd0);
        check("reset_mem_be_addr", {bus.mem_be, 14'd0, bus.mem_addr}, 32'd0);
        check("reset_acks_err", {bus.m_out_ready, bus.ext_ack, bus.err}, 32'd0);

        // word read at 0x10 with cycle-exact latency
        exp_read(32'hDEADBEEF);
        cpu_pulse(2'd3, 32'h0000_0010, 2'd0, 32'd0, 32'd0);
        check("rd_lat_c1_ready", bus.m_in_ready, 32'd0);
        @(posedge clk); #1;
        check("rd_c2_mem_en", bus.mem_en, 32'd1);
        check("rd_c2_mem_addr", bus.mem_addr, 32'd4);
        check("rd_c2_mem_be_we", {bus.mem_be, bus.mem_we}, {27'd0, 4'hF, 1'b0});
        check("rd_lat_c2_ready", bus.m_in_ready, 32'd0);
        @(posedge clk); #1;
        check("rd_c3_mem_en", bus.mem_en, 32'd0);
        check("rd_lat_c3_ready", bus.m_in_ready, 32'd0);
        @(posedge clk); #1;
        check("rd_lat_c4_ready", bus.m_in_ready, 32'd1);
        @(posedge clk); #1;
        check("rd_lat_c5_ready", bus.m_in_ready, 32'd0);
        wait_quiet(2);

        // byte write of A5 to 0x7
        exp_write();
        cpu_pulse(2'd0, 32'd0, 2'd1, 32'h0000_0007, 32'h0000_00A5);
        @(posedge clk); #1;
        check("bw_mem_en_we", {bus.mem_en, bus.mem_we}, 32'd3);
        check("bw_mem_be", bus.mem_be, 32'h8);
        check("bw_mem_wdata", bus.mem_wdata, 32'hA5A5A5A5);
        check("bw_mem_addr", bus.mem_addr, 32'd1);
        wait_quiet(2);

        cpu_read(2'd1, 32'h0000_0007, 32'h0000_00A5);
        cpu_read(2'd1, 32'h0000_0004, 32'h0000_0044);
        cpu_read(2'd2, 32'h0000_0003, 32'h0000_1234);
        cpu_read(2'd2, 32'h0000_0006, 32'h0000_A522);
        cpu_read(2'd3, 32'h0001_0010, 32'hDEADBEEF);

        // word write then half write into the upper half
        cpu_write(2'd3, 32'h0000_0008, 32'h55AA33CC);
        cpu_write(2'd2, 32'h0000_000A, 32'h0000BEEF);
        cpu_read(2'd3, 32'h0000_0008, 32'hBEEF33CC);

        // write and read pulsed together: the write is served first
        exp_write();
        exp_read(32'h12345677);
        cpu_pulse(2'd3, 32'h0000_0000, 2'd1, 32'h0000_0000, 32'h0000_0077);
        wait_quiet(2);

        // external write with ext_req dropped right after the grant, then read back
        exp_ext_op(1'b0, 32'd0);
        @(posedge clk); #1;
        bus.ext_req   = 1'b1;
        bus.ext_we    = 1'b1;
        bus.ext_addr  = 32'h0000_0020;
        bus.ext_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus.ext_req   = 1'b0;
        wait_quiet(2);
        exp_ext_op(1'b1, 32'hCAFEF00D);
        @(posedge clk); #1;
        ext_access(1'b0, 32'h0000_0020, 32'd0);
        wait_quiet(2);

        // arbitration alternation from reset
        do_reset();
        pair(1, 1'b0, 32'h0000_0010, 32'hDEADBEEF, 32'h0000_0020, 32'hCAFEF00D);
        cpu_read(2'd3, 32'h0000_0008, 32'hBEEF33CC);
        pair(1, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 32'h0000_0020, 32'hCAFEF00D);
        pair(0, 1'b1, 32'h0000_0008, 32'hBEEF33CC, 32'h0000_0010, 32'hDEADBEEF);

        // second read pulse while pending: dropped, sticky err
        check("err_clear_before", bus.err, 32'd0);
        exp_read(32'hDEADBEEF);
        @(posedge clk); #1;
        bus.m_in_sig_read = 2'd3;
        bus.m_in_addr     = 32'h0000_0010;
        repeat (2) @(posedge clk);
        #1 bus.m_in_sig_read = 2'd0;
        check("err_set", bus.err, 32'd1);
        wait_quiet(10);
        check("err_sticky", bus.err, 32'd1);
        do_reset();
        check("err_cleared_by_reset", bus.err, 32'd0);

        // reset during the RAM access cycle aborts the read silently
        cpu_pulse(2'd3, 32'h0000_0010, 2'd0, 32'd0, 32'd0);
        @(posedge clk); #1;
        check("abort_c2_mem_en", bus.mem_en, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_mem_en", bus.mem_en, 32'd0);
        check("abort_m_in_ready", bus.m_in_ready, 32'd0);
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("abort_err", bus.err, 32'd0);
        check("abort_no_data", bus.m_in_data, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
